regfile_wr_arbiter: RTL and testbench

Shares the register file's single write port among `NUM_REQ` writeback requesters (ROB commit, load unit, CSR/debug path) in the Tomasulo core. Each requester uses a valid/ready handshake. One request per cycle is granted, round-robin by default. The winner is registered onto the regfile's `we`/`waddr`/`wdata` inputs, so the regfile's internal forwarding covers the write cycle.

---
 rtl/regfile_wr_arbiter_pkg.sv | 28 ++
 rtl/regfile_wr_arbiter_rr_arbiter.sv | 35 +++
 rtl/regfile_wr_arbiter.sv | 82 ++++++++
 tb/tb_regfile_wr_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// regfile_wr_arbiter_pkg: shared regfile write-port constants, bus types and a one-hot index helper
package regfile_wr_arbiter_pkg;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam int RegAddrBus = 5;
    localparam int DataBus    = 32;

    localparam logic [DataBus-1:0]    ZeroWord = '0;
    localparam logic [RegAddrBus-1:0] ZeroReg  = '0;

    localparam int WRARB_MAX_REQ = 8;
    localparam int WRARB_IDX_W   = 3;

    typedef logic [RegAddrBus-1:0] reg_addr_t;
    typedef logic [DataBus-1:0]    data_t;

    // OR-reduction encoder: exact for one-hot input, zero for all-zero input
    function automatic logic [WRARB_IDX_W-1:0] onehot_idx(input logic [WRARB_MAX_REQ-1:0] oh);
        logic [WRARB_IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < WRARB_MAX_REQ; i++)
            if (oh[i]) r = r | WRARB_IDX_W'(i);
        return r;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot grant, round-robin from ptr (fixed lowest-index priority when WRARB_FIXED_PRIO_EN is defined)
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

`ifdef WRARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // isolate the lowest set request bit
    always_comb begin
        gnt = req & (~req + N'(1));
    end
`else
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] dgnt;
    logic [N-1:0]   rot;
    logic [N-1:0]   rgnt;

    // rotate so ptr sits at bit 0, pick the lowest set bit, rotate the grant back
    always_comb begin
        dbl  = {req, req} >> ptr;
        rot  = dbl[N-1:0];
        rgnt = rot & (~rot + N'(1));
        dgnt = {rgnt, rgnt} << ptr;
        gnt  = dgnt[2*N-1:N];
    end
`endif

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the regfile write port among NUM_REQ requesters; WRARB_FIXED_PRIO_EN selects fixed priority
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*5-1:0]       req_addr,
    input  logic [NUM_REQ*32-1:0]      req_data,
    output logic                       we,
    output logic [4:0]                 waddr,
    output logic [31:0]                wdata,
    output logic [$clog2(NUM_REQ)-1:0] wr_src
);

    localparam int PW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] arb_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gidx;
    reg_addr_t          gaddr;
    data_t              gdata;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // no grant while resetting or while the write port is stalled
    always_comb begin
        gnt  = (rst || stall) ? '0 : arb_gnt;
        gidx = PW'(onehot_idx(WRARB_MAX_REQ'(gnt)));
    end

    assign req_ready = gnt;

    // AND-OR select of the winning requester's address and data
    always_comb begin
        gaddr = ZeroReg;
        gdata = ZeroWord;
        for (int i = 0; i < NUM_REQ; i++) begin
            gaddr = gaddr | (req_addr[RegAddrBus*i +: RegAddrBus] & {RegAddrBus{gnt[i]}});
            gdata = gdata | (req_data[DataBus*i +: DataBus] & {DataBus{gnt[i]}});
        end
    end

`ifdef WRARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    // priority pointer moves just past the last winner
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (|gnt)
            ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
    end
`endif

    // registered write port; x0 writes are accepted but never enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            we     <= WriteDisable;
            waddr  <= ZeroReg;
            wdata  <= ZeroWord;
            wr_src <= '0;
        end else if (|gnt) begin
            we     <= (gaddr != ZeroReg) ? WriteEnable : WriteDisable;
            waddr  <= gaddr;
            wdata  <= gdata;
            wr_src <= gidx;
        end else begin
            we     <= WriteDisable;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and randomized checks of regfile_wr_arbiter against a behavioural model
module tb_regfile_wr_arbiter;

    localparam int NR = 3;

    logic            clk = 0;
    logic            rst;
    logic            stall;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*5-1:0] req_addr;
    logic [NR*32-1:0] req_data;
    logic            we;
    logic [4:0]      waddr;
    logic [31:0]     wdata;
    logic [1:0]      wr_src;

    regfile_wr_arbiter #(.NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .wr_src    (wr_src)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [NR-1:0] v;
    logic [4:0]    a [NR];
    logic [31:0]   d [NR];
    logic [NR-1:0] last_ready;

    int          m_ptr;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    int          e_src;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic cycle(input bit r, input bit s);
        int g;
        rst = r;
        stall = s;
        req_valid = v;
        for (int i = 0; i < NR; i++) begin
            req_addr[5*i +: 5]   = a[i];
            req_data[32*i +: 32] = d[i];
        end
        #1;
        g = (r || s) ? -1 : winner();
        chk("ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        last_ready = req_ready;
        if (r) begin
            e_we = 0; e_waddr = 0; e_wdata = 0; e_src = 0; m_ptr = 0;
        end else if (g >= 0) begin
            e_we = (a[g] != 0);
            e_waddr = a[g];
            e_wdata = d[g];
            e_src = g;
`ifndef WRARB_FIXED_PRIO_EN
            m_ptr = (g + 1) % NR;
`endif
        end else begin
            e_we = 0;
        end
        @(posedge clk);
        #1;
        chk("we", 32'(we), 32'(e_we));
        chk("waddr", 32'(waddr), 32'(e_waddr));
        chk("wdata", wdata, e_wdata);
        chk("wr_src", 32'(wr_src), 32'(e_src));
        if (g >= 0) v[g] = 0;
    endtask

    initial begin
        v = '0;
        m_ptr = 0; e_we = 0; e_waddr = 0; e_wdata = 0; e_src = 0;
        for (int i = 0; i < NR; i++) begin
            a[i] = 5'(i + 1);
            d[i] = $urandom;
        end
        #2;

        // reset then idle, with every requester valid during reset
        v = '1;
        cycle(1, 0);
        cycle(1, 0);
        chk("rst_ready", 32'(last_ready), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_src", 32'(wr_src), 0);

        // single requester
        v = 3'b010; a[1] = 5'd5; d[1] = 32'hDEADBEEF;
        cycle(0, 0);
        chk("single_ready", 32'(last_ready), 32'b010);
        chk("single_we", 32'(we), 1);
        chk("single_waddr", 32'(waddr), 5);
        chk("single_wdata", wdata, 32'hDEADBEEF);
        chk("single_src", 32'(wr_src), 1);
        cycle(0, 0);
        chk("single_idle_we", 32'(we), 0);

        // full contention
        cycle(1, 0);
        for (int i = 0; i < 6; i++) begin
            v = '1;
            cycle(0, 0);
`ifdef WRARB_FIXED_PRIO_EN
            chk("cont_src", 32'(wr_src), 0);
`else
            chk("cont_src", 32'(wr_src), 32'(i % 3));
`endif
            chk("cont_we", 32'(we), 1);
        end

        // stall in cycles 2-3
        cycle(1, 0);
        for (int c = 0; c < 6; c++) begin
            v = '1;
            cycle(0, c == 2 || c == 3);
            if (c == 2 || c == 3) chk("stall_ready", 32'(last_ready), 0);
            chk("stall_we", 32'(we), (c == 2 || c == 3) ? 0 : 1);
`ifdef WRARB_FIXED_PRIO_EN
            if (c == 4) chk("stall_resume", 32'(wr_src), 0);
`else
            if (c == 4) chk("stall_resume", 32'(wr_src), 2);
`endif
        end

        // write to x0
        cycle(1, 0);
        v = 3'b001; a[0] = 5'd0; d[0] = 32'h12345678;
        cycle(0, 0);
        chk("x0_ready", 32'(last_ready), 1);
        chk("x0_we", 32'(we), 0);
        chk("x0_wdata", wdata, 32'h12345678);
        chk("x0_src", 32'(wr_src), 0);
        v = '1; a[0] = 5'd9;
        cycle(0, 0);
`ifdef WRARB_FIXED_PRIO_EN
        chk("x0_next", 32'(wr_src), 0);
`else
        chk("x0_next", 32'(wr_src), 1);
`endif

        // reset in the cycle after a grant
        cycle(1, 0);
        v = 3'b001;
        cycle(0, 0);
        chk("mid_grant_we", 32'(we), 1);
        v = '1;
        cycle(1, 0);
        chk("mid_rst_we", 32'(we), 0);
        cycle(0, 0);
        chk("mid_after_src", 32'(wr_src), 0);

        // randomized traffic honouring the hold-until-transfer rule
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v[i] && ($urandom % 3 != 0)) begin
                    v[i] = 1;
                    a[i] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
                    d[i] = $urandom;
                end
            end
            cycle($urandom % 50 == 0, $urandom % 5 == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
